// File: rtl/des_subkey_stream_pkg.sv
// Shared DES key-schedule definitions: permutation tables, shift schedule,
// width constants and the subkey-stream state encoding.
package des_subkey_stream_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int SUBKEY_W = 48;
    localparam int HALF_W   = 28;
    localparam int ROUNDS   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Tables use FIPS 46 numbering: entry i names the source bit (1 = MSB)
    // of output bit i+1.
    localparam int PC1_TABLE [0:CD_W-1] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [0:SUBKEY_W-1] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotation amount applied to reach round r (entry r-1).
    localparam logic [1:0] SHIFT_TABLE [0:ROUNDS-1] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [1:0] shift_amt(input logic [4:0] round);
        logic [3:0] idx;
        idx = 4'(round - 5'd1);
        return SHIFT_TABLE[idx];
    endfunction

endpackage

// File: rtl/des_subkey_stream_pc2.sv
// DES Permuted Choice 2: selects the 48 round-subkey bits from a 56-bit CD value.
module des_pc2
    import des_subkey_stream_pkg::*;
(
    input  logic [CD_W-1:0]     cd,
    output logic [SUBKEY_W-1:0] subkey
);

    // Eight CD bits (9,18,22,25,35,38,43,54) are dropped by PC-2 by design.
    logic cd_dropped_unused;
    assign cd_dropped_unused = ^{cd[47], cd[38], cd[34], cd[31],
                                 cd[21], cd[18], cd[13], cd[2]};

    always_comb begin
        subkey = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            subkey[SUBKEY_W-1-i] = cd[CD_W-PC2_TABLE[i]];
        end
    end

endmodule

// File: rtl/des_subkey_stream.sv
// Streams the sixteen DES round subkeys of a latched key, in encrypt or
// decrypt order, over a valid/ready handshake.
module des_subkey_stream
    import des_subkey_stream_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                decrypt,
    input  logic                start,
    input  logic                ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                subkey_valid,
    output logic [4:0]          round_id,
    output logic                last,
    output logic                busy,
    output logic                done
);

    // Handshake: subkey/round_id/last are offered whenever subkey_valid=1 and
    // are consumed on a rising edge where subkey_valid=1 and ready=1; while
    // ready=0 they hold. subkey_valid does not depend on ready.

    state_t              state;
    state_t              state_nx;
    logic [CD_W-1:0]     cd;
    logic                dec_q;
    logic                load;
    logic                advance;
    logic                final_hs;
    logic                is_final;
    logic [CD_W-1:0]     pc1_key;
    logic [HALF_W-1:0]   c_half;
    logic [HALF_W-1:0]   d_half;
    logic [1:0]          fwd_amt;
    logic [1:0]          rev_amt;

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0] n);
        return (n == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                           : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                           : {x[0], x[HALF_W-1:1]};
    endfunction

    function automatic logic [CD_W-1:0] pc1_perm(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < CD_W; i++) begin
            r[CD_W-1-i] = k[KEY_W-PC1_TABLE[i]];
        end
        return r;
    endfunction

    // Parity bits 8,16,...,64 of the key never enter the schedule.
    logic key_parity_unused;
    assign key_parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                 key_in[24], key_in[16], key_in[8],  key_in[0]};

    assign pc1_key  = pc1_perm(key_in);
    assign c_half   = cd[CD_W-1:HALF_W];
    assign d_half   = cd[HALF_W-1:0];
    assign fwd_amt  = shift_amt(round_id + 5'd1);
    assign rev_amt  = shift_amt(round_id);
    assign is_final = dec_q ? (round_id == 5'd1) : (round_id == 5'd16);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        load         = 1'b0;
        advance      = 1'b0;
        final_hs     = 1'b0;
        subkey_valid = 1'b0;
        busy         = 1'b0;
        last         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                subkey_valid = 1'b1;
                busy         = 1'b1;
                last         = is_final;
                if (ready) begin
                    if (is_final) begin
                        final_hs = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // CD is left untouched on the final handshake so the last subkey keeps
    // being presented (unvalidated) while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cd       <= '0;
            round_id <= '0;
            dec_q    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= final_hs;
            if (load) begin
                dec_q <= decrypt;
                if (decrypt) begin
                    cd       <= pc1_key;
                    round_id <= 5'd16;
                end else begin
                    cd       <= {rotl28(pc1_key[CD_W-1:HALF_W], 2'd1),
                                 rotl28(pc1_key[HALF_W-1:0], 2'd1)};
                    round_id <= 5'd1;
                end
            end else if (advance) begin
                if (dec_q) begin
                    cd       <= {rotr28(c_half, rev_amt), rotr28(d_half, rev_amt)};
                    round_id <= round_id - 5'd1;
                end else begin
                    cd       <= {rotl28(c_half, fwd_amt), rotl28(d_half, fwd_amt)};
                    round_id <= round_id + 5'd1;
                end
            end
        end
    end

    des_pc2 u_pc2 (
        .cd     (cd),
        .subkey (subkey)
    );

endmodule
